// File: rtl/ovr_i_shtdwn_if.sv
// rtl/ovr_i_shtdwn_if.sv - PWM sync, comparator, clear and shutdown signal bundle for ovr_i_shtdwn
interface ovr_i_shtdwn_if;
    logic       PWM_synch;
    logic       OVR_I_lft;
    logic       OVR_I_rght;
    logic       clr_shtdwn;
    logic       OVR_I_shtdwn;
    logic       ovr_window;
    logic [7:0] evt_cnt;

    modport master (
        output PWM_synch,
        output OVR_I_lft,
        output OVR_I_rght,
        output clr_shtdwn,
        input  OVR_I_shtdwn,
        input  ovr_window,
        input  evt_cnt
    );

    modport slave (
        input  PWM_synch,
        input  OVR_I_lft,
        input  OVR_I_rght,
        input  clr_shtdwn,
        output OVR_I_shtdwn,
        output ovr_window,
        output evt_cnt
    );
endinterface

// File: rtl/ovr_i_shtdwn.sv
// rtl/ovr_i_shtdwn.sv - over-current supervisor, windowed sampling and latched shutdown (optional leaky counter: OVR_I_LEAKY_EN)
module ovr_i_shtdwn #(
    parameter logic [10:0] BLANK_START = 11'd128,
    parameter logic [10:0] BLANK_END   = 11'd255,
    parameter logic [7:0]  MAX_EVENTS  = 8'd40
) (
    input  logic          clk,
    input  logic          rst_n,
    ovr_i_shtdwn_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        SAMPLE,
        WAIT,
        SHTDWN
    } state_t;

    state_t      state;
    logic        lft_meta;
    logic        lft_s;
    logic        rght_meta;
    logic        rght_s;
    logic        ovr_s;
    logic [10:0] pos;
    logic [10:0] pos_nxt;
    logic        flag;
    logic [7:0]  cnt;
    logic [7:0]  cnt_eval;
    logic        shtdwn;
    logic        window;
    logic        enter_win;
    state_t      enter_state;

    assign bus.OVR_I_shtdwn = shtdwn;
    assign bus.ovr_window   = window;
    assign bus.evt_cnt      = cnt;

    // Two-flop synchronizers for the asynchronous comparator outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_meta  <= 1'b0;
            lft_s     <= 1'b0;
            rght_meta <= 1'b0;
            rght_s    <= 1'b0;
        end else begin
            lft_meta  <= bus.OVR_I_lft;
            lft_s     <= lft_meta;
            rght_meta <= bus.OVR_I_rght;
            rght_s    <= rght_meta;
        end
    end

    assign ovr_s = lft_s | rght_s;

    // Next PWM-period position: restart on sync, otherwise count up and stick at the top
    always_comb begin
        pos_nxt = pos;
        if (bus.PWM_synch) begin
            pos_nxt = '0;
        end else if (pos != 11'h7FF) begin
            pos_nxt = pos + 11'd1;
        end
    end

    // Position counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
        end else begin
            pos <= pos_nxt;
        end
    end

    // Counter value produced by evaluating the period that just ended
    always_comb begin
        cnt_eval = cnt;
        if (flag) begin
            if (cnt != 8'hFF) begin
                cnt_eval = cnt + 8'd1;
            end
        end
`ifdef OVR_I_LEAKY_EN
        else if (cnt != 8'h00) begin
            cnt_eval = cnt - 8'd1;
        end
`endif
    end

    // A new period normally starts blanked; it opens straight into sampling only if the window begins at 0
    assign enter_win   = (pos_nxt == BLANK_START);
    assign enter_state = enter_win ? SAMPLE : BLANK;

    // Period state machine with registered window, counter and shutdown outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            flag   <= 1'b0;
            cnt    <= '0;
            shtdwn <= 1'b0;
            window <= 1'b0;
        end else if (bus.clr_shtdwn && !ovr_s) begin
            // Clear is refused while the fault is still present, and wins over a period evaluation
            state  <= IDLE;
            flag   <= 1'b0;
            cnt    <= '0;
            shtdwn <= 1'b0;
            window <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.PWM_synch) begin
                        state  <= enter_state;
                        window <= enter_win;
                    end
                end
                BLANK, SAMPLE, WAIT: begin
                    if (bus.PWM_synch) begin
                        // End of period (normal or short): score it with the flag as it stands
                        cnt  <= cnt_eval;
                        flag <= 1'b0;
                        if (cnt_eval >= MAX_EVENTS) begin
                            state  <= SHTDWN;
                            shtdwn <= 1'b1;
                            window <= 1'b0;
                        end else begin
                            state  <= enter_state;
                            window <= enter_win;
                        end
                    end else if (state == BLANK) begin
                        if (pos_nxt == BLANK_START) begin
                            state  <= SAMPLE;
                            window <= 1'b1;
                        end
                    end else if (state == SAMPLE) begin
                        if (ovr_s) begin
                            flag <= 1'b1;
                        end
                        if (pos == BLANK_END) begin
                            state  <= WAIT;
                            window <= 1'b0;
                        end
                    end
                end
                SHTDWN: begin
                    state <= SHTDWN;
                end
                default: begin
                    state  <= IDLE;
                    window <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ovr_i_shtdwn.sv
// tb/tb_ovr_i_shtdwn.sv - self-checking bench for ovr_i_shtdwn with a behavioural window model
module tb_ovr_i_shtdwn;

    localparam logic [10:0] BS   = 11'd128;
    localparam logic [10:0] BE   = 11'd255;
    localparam logic [7:0]  MAXE = 8'd40;
`ifdef OVR_I_LEAKY_EN
    localparam int EXP_DECAY = 6;
`else
    localparam int EXP_DECAY = 10;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   chk_en  = 1'b0;

    always #5 clk = ~clk;

    ovr_i_shtdwn_if bus ();

    ovr_i_shtdwn #(
        .BLANK_START(BS),
        .BLANK_END  (BE),
        .MAX_EVENTS (MAXE)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    // Behavioural model: a period is "hit" if the synchronized comparator was high at any
    // in-window position; each period end after the first scores it; shutdown latches at MAXE.
    int m_pos;
    int m_cnt;
    bit m_started, m_shut, m_hit, m_win, m_p1, m_p2, m_os, m_pin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos = 0; m_cnt = 0; m_started = 0; m_shut = 0;
            m_hit = 0; m_win = 0; m_p1 = 0; m_p2 = 0;
        end else begin
            m_os  = m_p2;
            m_pin = bus.OVR_I_lft | bus.OVR_I_rght;
            if (bus.clr_shtdwn && !m_os) begin
                m_cnt = 0; m_hit = 0; m_shut = 0; m_started = 0;
            end else if (!m_shut) begin
                if (bus.PWM_synch) begin
                    if (m_started) begin
                        if (m_hit) begin
                            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
                        end else begin
`ifdef OVR_I_LEAKY_EN
                            if (m_cnt > 0) m_cnt = m_cnt - 1;
`endif
                        end
                        m_hit = 0;
                        if (m_cnt >= int'(MAXE)) m_shut = 1;
                    end
                    m_started = 1;
                end else if (m_win && m_os) begin
                    m_hit = 1;
                end
            end
            m_pos = bus.PWM_synch ? 0 : ((m_pos < 2047) ? m_pos + 1 : 2047);
            m_win = m_started && !m_shut && (m_pos >= int'(BS)) && (m_pos <= int'(BE));
            m_p2  = m_p1;
            m_p1  = m_pin;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model
    always @(posedge clk) begin
        #1;
        if (chk_en && rst_n) begin
            chk("model_shtdwn", {31'd0, bus.OVR_I_shtdwn}, {31'd0, m_shut});
            chk("model_window", {31'd0, bus.ovr_window}, {31'd0, m_win});
            chk("model_evt_cnt", {24'd0, bus.evt_cnt}, m_cnt);
        end
    end

    task automatic step(input bit s, input bit l, input bit r, input bit c);
        @(negedge clk);
        bus.PWM_synch  = s;
        bus.OVR_I_lft  = l;
        bus.OVR_I_rght = r;
        bus.clr_shtdwn = c;
    endtask

    task automatic after_edge;
        @(posedge clk);
        #2;
    endtask

    // One PWM period of len cycles; comparator high for cycle offsets in [a0,a1] or [b0,b1]
    task automatic period(input int len, input bit use_l, input int a0, input int a1,
                          input int b0, input int b1);
        for (int i = 0; i < len; i++) begin
            bit on;
            on = ((i >= a0) && (i <= a1)) || ((i >= b0) && (i <= b1));
            step(i == 0, use_l && on, !use_l && on, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, mode, a0, a1;
        bit on, cl;
        bus.PWM_synch = 0; bus.OVR_I_lft = 0; bus.OVR_I_rght = 0; bus.clr_shtdwn = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_shtdwn", {31'd0, bus.OVR_I_shtdwn}, 0);
        chk("reset_window", {31'd0, bus.ovr_window}, 0);
        chk("reset_evt_cnt", {24'd0, bus.evt_cnt}, 0);
        @(negedge clk);
        rst_n  = 1;
        chk_en = 1;

        // Persistent left fault: one count per period, shutdown on the 40th evaluation
        for (int p = 0; p < 40; p++) period(400, 1, 0, 399, 1, 0);
        after_edge;
        chk("held_cnt39", {24'd0, bus.evt_cnt}, 39);
        chk("held_not_shut", {31'd0, bus.OVR_I_shtdwn}, 0);
        step(1, 1, 0, 0);
        after_edge;
        chk("held_cnt40", {24'd0, bus.evt_cnt}, 40);
        chk("held_shut", {31'd0, bus.OVR_I_shtdwn}, 1);

        // Clear refused while fault present, accepted once quiet
        step(0, 1, 0, 1);
        after_edge;
        chk("clr_refused", {31'd0, bus.OVR_I_shtdwn}, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        after_edge;
        chk("clr_shtdwn", {31'd0, bus.OVR_I_shtdwn}, 0);
        chk("clr_cnt", {24'd0, bus.evt_cnt}, 0);

        // Right fault only outside the window: fully blanked
        for (int p = 0; p < 50; p++) period(600, 0, 10, 100, 300, 590);
        step(1, 0, 0, 0);
        after_edge;
        chk("blank_cnt", {24'd0, bus.evt_cnt}, 0);
        chk("blank_shut", {31'd0, bus.OVR_I_shtdwn}, 0);

        // Short pulse inside the window counts one period
        period(400, 1, 199, 201, 1, 0);
        step(1, 0, 0, 0);
        after_edge;
        chk("pulse_cnt", {24'd0, bus.evt_cnt}, 1);

        // 10 faulty then 4 clean periods
        step(0, 0, 0, 1);
        after_edge;
        chk("clr2_cnt", {24'd0, bus.evt_cnt}, 0);
        for (int p = 0; p < 10; p++) period(300, 1, 0, 299, 1, 0);
        for (int p = 0; p < 4; p++) period(300, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0);
        after_edge;
        chk("decay_cnt", {24'd0, bus.evt_cnt}, EXP_DECAY);

        // Reach 20, reset in mid-window
        step(0, 0, 0, 1);
        for (int p = 0; p < 20; p++) period(300, 1, 0, 299, 1, 0);
        step(1, 1, 0, 0);
        repeat (150) step(0, 1, 0, 0);
        after_edge;
        chk("pre_rst_cnt", {24'd0, bus.evt_cnt}, 20);
        chk("pre_rst_window", {31'd0, bus.ovr_window}, 1);
        #1;
        rst_n = 0;
        bus.OVR_I_lft = 0;
        #1;
        chk("rst_shtdwn", {31'd0, bus.OVR_I_shtdwn}, 0);
        chk("rst_window", {31'd0, bus.ovr_window}, 0);
        chk("rst_cnt", {24'd0, bus.evt_cnt}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        for (int p = 0; p < 2; p++) period(300, 1, 0, 299, 1, 0);
        step(1, 0, 0, 0);
        after_edge;
        chk("resume_cnt", {24'd0, bus.evt_cnt}, 2);

        // Randomized periods, including short ones that end mid-blank or mid-window
        repeat (30) begin
            len  = int'($urandom_range(60, 520));
            mode = int'($urandom_range(0, 3));
            a0   = int'($urandom_range(0, len - 1));
            a1   = a0 + int'($urandom_range(0, 60));
            for (int i = 0; i < len; i++) begin
                on = (i >= a0) && (i <= a1);
                cl = ($urandom_range(0, 199) == 0);
                case (mode)
                    1:       step(i == 0, on, 1'b0, cl);
                    2:       step(i == 0, 1'b0, on, cl);
                    3:       step(i == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, cl);
                    default: step(i == 0, 1'b0, 1'b0, cl);
                endcase
            end
        end
        step(1, 0, 0, 0);
        repeat (3) step(0, 0, 0, 0);
        after_edge;
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ovr_i_shtdwn.md
Name: ovr_i_shtdwn

Overview:
- Over-current supervisor inside the motor drive (iDRV). It produces the OVR_I_shtdwn flag that the drive uses to force both H-bridges off.
- Watches the asynchronous OVR_I_lft/OVR_I_rght comparator outputs from the H-bridges. Samples them only inside a window of each PWM period, after switching noise has settled.
- Counts PWM periods that contain over-current and latches shutdown once the count reaches a limit.

Parameters:
- BLANK_START, 11'd128, PWM-period position (clocks after PWM_synch) at which sampling begins; blanking applies before it.
- BLANK_END, 11'd255, last PWM-period position at which sampling is active (inclusive).
- MAX_EVENTS, 8'd40, number of counted over-current periods that latches shutdown.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- PWM_synch  input  1  one-clock pulse marking the start of each PWM period (from PWM11)
- OVR_I_lft  input  1  left H-bridge over-current comparator, asynchronous
- OVR_I_rght  input  1  right H-bridge over-current comparator, asynchronous
- clr_shtdwn  input  1  one-clock request to clear the latched shutdown and the counter
- OVR_I_shtdwn  output  1  latched shutdown to the drive; 1 = both motors off
- ovr_window  output  1  high while the sampling window is active (debug)
- evt_cnt  output  8  current over-current period count

Behaviour:
- Reset: all flops clear asynchronously on rst_n low.
  - OVR_I_shtdwn=0, ovr_window=0, evt_cnt=0, pos=0, period flag=0, state=IDLE.
- Input synchronization:
  - OVR_I_lft and OVR_I_rght each pass through a 2-flop synchronizer.
  - ovr_s = lft_s | rght_s; latency 2 clocks from pin to ovr_s.
- Position counter:
  - 11-bit pos loads 0 on PWM_synch; otherwise increments, saturating at 11'h7FF.
- State machine:
  - IDLE: wait for PWM_synch -> BLANK.
  - BLANK: when the next pos equals BLANK_START -> SAMPLE.
  - SAMPLE: ovr_window=1 (registered, asserted exactly for pos in [BLANK_START, BLANK_END]). If ovr_s=1, set the period flag. After pos==BLANK_END -> WAIT.
  - WAIT: on PWM_synch, evaluate the period (see below), clear the flag, go to BLANK.
  - PWM_synch arriving in BLANK or SAMPLE (short period): evaluate the period with the flag as it stands, restart at BLANK. ovr_window drops the same cycle.
  - SHTDWN: entered when evt_cnt reaches MAX_EVENTS.
    - OVR_I_shtdwn=1 on the clock after the evaluation that brings evt_cnt to MAX_EVENTS.
    - Stays in SHTDWN regardless of PWM_synch or inputs; evt_cnt holds at MAX_EVENTS.
- Period evaluation:
  - If the flag is set, evt_cnt += 1, saturating at 8'hFF.
  - If the flag is clear, behaviour depends on the optional feature.
- Blanking:
  - ovr_s high outside [BLANK_START, BLANK_END] is ignored entirely.
- Clear:
  - clr_shtdwn=1 with ovr_s=0: evt_cnt=0, flag=0, OVR_I_shtdwn=0 on the next clock, state=IDLE.
  - clr_shtdwn=1 with ovr_s=1: the request is ignored and shutdown stays latched.
  - Clear takes priority over a simultaneous period evaluation.
- Reset mid-period returns everything to reset values immediately.
- MAX_EVENTS=1: the first flagged period shuts down.

Optional Feature:
- Macro: OVR_I_LEAKY_EN.
- Defined: a period evaluated with the flag clear decrements evt_cnt, saturating at 0. Intermittent faults then decay instead of accumulating.
- Undefined: a clean period leaves evt_cnt unchanged. Only clr_shtdwn or reset lowers it.

Test Plan:
- PWM_synch every 2048 clks, OVR_I_lft held 1 -> evt_cnt increments once per period. OVR_I_shtdwn rises 1 clk after the 40th period evaluation.
- OVR_I_rght pulsed high only at pos 10..100 and 300..2000 for 50 periods -> evt_cnt stays 0, OVR_I_shtdwn stays 0 (blanking).
- Single OVR_I_lft pulse at pos 200 (held 3 clks) in one period -> evt_cnt=1 after the next PWM_synch.
- Latch shutdown, then clr_shtdwn with OVR_I_lft=1 -> still 1. Drop the inputs, wait 2 clks, pulse clr_shtdwn -> OVR_I_shtdwn=0, evt_cnt=0 next clk.
- With OVR_I_LEAKY_EN: 10 faulty then 4 clean periods -> evt_cnt=6. Without the macro -> evt_cnt=10.
- Assert rst_n low during SAMPLE with evt_cnt=20 -> all outputs 0 immediately. Normal counting resumes after release and the next PWM_synch.
